// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared BG register-write types and commit FSM states
package bg_pkg;

    localparam int BG_REG_AW = 3;
    localparam int BG_REG_DW = 32;

    typedef struct packed {
        logic [BG_REG_AW-1:0] addr;
        logic [BG_REG_DW-1:0] data;
    } bg_reg_wr_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2
    } bg_commit_state_e;

endpackage

// File: rtl/bg_reg_fifo.sv
// rtl/bg_reg_fifo.sv - synchronous FIFO of BG register writes
// Caller only pops when not empty and only pushes when not full or popping in the same cycle.
module bg_reg_fifo
    import bg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  bg_reg_wr_t             push_data_i,
    input  logic                   pop_i,
    output bg_reg_wr_t             pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    bg_reg_wr_t        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the level counter gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule

// File: rtl/bg_reg_commit.sv
// rtl/bg_reg_commit.sv - buffers host BG register writes and replays them only during vblank
// Optional drop counter output oDROP_COUNT enabled by BG_COMMIT_DROPCNT_EN.
module bg_reg_commit
    import bg_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SY_W     = 10,
    parameter int V_ACTIVE = 480
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET,
    input  logic [SY_W-1:0]        iSY,
    input  logic [2:0]             iHOST_ADDR,
    input  logic [31:0]            iHOST_DATA,
    input  logic                   iHOST_WRITE,
    input  logic                   iOVF_CLR,
    output logic [2:0]             oREG_ADDR,
    output logic [31:0]            oREG_DATA,
    output logic                   oREG_WRITE,
    output logic [$clog2(DEPTH):0] oLEVEL,
    output logic                   oOVERFLOW,
    output logic                   oFRAME_DONE
`ifdef BG_COMMIT_DROPCNT_EN
    ,
    output logic [7:0]             oDROP_COUNT
`endif
);

    bg_commit_state_e state_q, state_d;
    bg_reg_wr_t       reg_wr_q, reg_wr_d;
    bg_reg_wr_t       host_wr;
    bg_reg_wr_t       head;
    logic             reg_write_q;
    logic             ovf_q, ovf_d;
    logic             frame_done_q, frame_done_d;
    logic             vb;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;

    assign vb      = (iSY >= SY_W'(V_ACTIVE));
    assign host_wr = '{addr: iHOST_ADDR, data: iHOST_DATA};
    // A full FIFO still accepts a write when an entry leaves in the same cycle.
    assign push    = iHOST_WRITE && (!full || pop);
    assign drop    = iHOST_WRITE && full && !pop;

    bg_reg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (iCLOCK),
        .rst_i       (iRESET),
        .push_i      (push),
        .push_data_i (host_wr),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (oLEVEL)
    );

    // HOLD pops directly so a write arriving mid-vblank lands two cycles later.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (vb) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    frame_done_d = 1'b1;
                    state_d      = HOLD;
                end else if (!vb) begin
                    state_d = ACTIVE;
                end else begin
                    pop = 1'b1;
                end
            end
            HOLD: begin
                if (!vb) begin
                    state_d = ACTIVE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = DRAIN;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_comb begin
        reg_wr_d = pop ? head : reg_wr_q;
        ovf_d    = ovf_q;
        if (drop)          ovf_d = 1'b1;
        else if (iOVF_CLR) ovf_d = 1'b0;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_q      <= ACTIVE;
            reg_wr_q     <= '0;
            reg_write_q  <= 1'b0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_wr_q     <= reg_wr_d;
            reg_write_q  <= pop;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BG_COMMIT_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (iOVF_CLR) begin
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) drop_cnt_q <= 8'd0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign oDROP_COUNT = drop_cnt_q;
`endif

    assign oREG_ADDR   = reg_wr_q.addr;
    assign oREG_DATA   = reg_wr_q.data;
    assign oREG_WRITE  = reg_write_q;
    assign oOVERFLOW   = ovf_q;
    assign oFRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_bg_reg_commit.sv
// tb/tb_bg_reg_commit.sv - directed scoreboard bench for bg_reg_commit
module tb_bg_reg_commit;
    import bg_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  sy;
    logic [2:0]  h_addr;
    logic [31:0] h_data;
    logic        h_wr;
    logic        ovf_clr;
    logic [2:0]  r_addr;
    logic [31:0] r_data;
    logic        r_wr;
    logic [4:0]  level;
    logic        ovf;
    logic        fdone;
`ifdef BG_COMMIT_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int wr_cnt   = 0;
    int fd_cnt   = 0;
    int last_wr_cyc = -1;
    int fd_cyc      = -1;
    int mark, wr0, fd0;
    bg_reg_wr_t exp_q[$];

    bg_reg_commit #(.DEPTH(16), .SY_W(10), .V_ACTIVE(480)) dut (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iSY         (sy),
        .iHOST_ADDR  (h_addr),
        .iHOST_DATA  (h_data),
        .iHOST_WRITE (h_wr),
        .iOVF_CLR    (ovf_clr),
        .oREG_ADDR   (r_addr),
        .oREG_DATA   (r_data),
        .oREG_WRITE  (r_wr),
        .oLEVEL      (level),
        .oOVERFLOW   (ovf),
        .oFRAME_DONE (fdone)
`ifdef BG_COMMIT_DROPCNT_EN
        ,
        .oDROP_COUNT (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        bg_reg_wr_t e;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (r_wr === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(r_addr), 64'(e.addr));
                chk("wr_data", 64'(r_data), 64'(e.data));
            end
        end
        if (fdone === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc_n;
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [31:0] d, input bit accepted);
        h_addr = a;
        h_data = d;
        h_wr   = 1'b1;
        if (accepted) exp_q.push_back('{addr: a, data: d});
        cyc();
        h_wr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; sy = 10'd100; h_addr = '0; h_data = '0; h_wr = 1'b0; ovf_clr = 1'b0;
        run(3);
        chk("rst_reg_write", 64'(r_wr), 64'd0);
        chk("rst_reg_addr", 64'(r_addr), 64'd0);
        chk("rst_reg_data", 64'(r_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(ovf), 64'd0);
        chk("rst_frame_done", 64'(fdone), 64'd0);
        rst = 1'b0;
        run(2);

        // three writes outside vblank, then drain
        host_wr(3'd1, 32'd1, 1'b1);
        host_wr(3'd2, 32'd2, 1'b1);
        host_wr(3'd3, 32'd3, 1'b1);
        cyc();
        chk("t1_no_write_active", 64'(wr_cnt), 64'd0);
        chk("t1_level3", 64'(level), 64'd3);
        sy = 10'd480;
        mark = cyc_n;
        run(8);
        chk("t1_write_count", 64'(wr_cnt), 64'd3);
        chk("t1_last_write_cycle", 64'(last_wr_cyc), 64'(mark + 4));
        chk("t1_frame_done_count", 64'(fd_cnt), 64'd1);
        chk("t1_frame_done_cycle", 64'(fd_cyc), 64'(mark + 5));
        chk("t1_level0", 64'(level), 64'd0);
        chk("t1_hold_addr", 64'(r_addr), 64'd3);
        chk("t1_hold_data", 64'(r_data), 64'd3);

        // single write mid-vblank with empty FIFO: t+2 latency
        wr0 = wr_cnt; fd0 = fd_cnt;
        mark = cyc_n;
        host_wr(3'd5, 32'hDEADBEEF, 1'b1);
        run(4);
        chk("t2_write_count", 64'(wr_cnt - wr0), 64'd1);
        chk("t2_latency", 64'(last_wr_cyc), 64'(mark + 2));
        chk("t2_frame_done", 64'(fd_cnt - fd0), 64'd1);

        // fill to 16, drop the 17th
        sy = 10'd100;
        run(2);
        for (int i = 0; i < 16; i++) host_wr(3'(i), 32'h100 + 32'(i), 1'b1);
        host_wr(3'd7, 32'hBAD, 1'b0);
        cyc();
        chk("t3_level16", 64'(level), 64'd16);
        chk("t3_overflow_set", 64'(ovf), 64'd1);
`ifdef BG_COMMIT_DROPCNT_EN
        chk("t3_drop_count", 64'(drop_cnt), 64'd1);
`endif
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        cyc();
        chk("t3_overflow_cleared", 64'(ovf), 64'd0);
        chk("t3_level_kept", 64'(level), 64'd16);

        // full FIFO in DRAIN accepts a simultaneous write
        wr0 = wr_cnt; fd0 = fd_cnt;
        sy = 10'd480;
        cyc();
        host_wr(3'd6, 32'h600D, 1'b1);
        chk("t5_level_stays16", 64'(level), 64'd16);
        run(2);
        chk("t5_no_overflow", 64'(ovf), 64'd0);
        run(20);
        chk("t5_write_count", 64'(wr_cnt - wr0), 64'd17);
        chk("t5_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("t5_level0", 64'(level), 64'd0);

        // short vblank: only 4 of 10 drain, rest wait for the next one
        sy = 10'd100;
        run(2);
        for (int i = 0; i < 10; i++) host_wr(3'(i + 2), 32'h2000 + 32'(i * 7), 1'b1);
        wr0 = wr_cnt; fd0 = fd_cnt;
        sy = 10'd480;
        run(5);
        sy = 10'd100;
        run(3);
        chk("t4_partial_writes", 64'(wr_cnt - wr0), 64'd4);
        chk("t4_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
        chk("t4_level6", 64'(level), 64'd6);
        sy = 10'd480;
        run(12);
        chk("t4_resume_writes", 64'(wr_cnt - wr0), 64'd10);
        chk("t4_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("t4_level0", 64'(level), 64'd0);

        // reset mid-drain with 5 entries left
        sy = 10'd100;
        run(2);
        for (int i = 0; i < 10; i++) host_wr(3'(7 - (i % 8)), 32'hA5A50000 | 32'(i), 1'b1);
        wr0 = wr_cnt;
        sy = 10'd480;
        run(6);
        chk("t6_writes_before_reset", 64'(wr_cnt - wr0), 64'd5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        exp_q.delete();
        chk("t6_reg_write_after_reset", 64'(r_wr), 64'd0);
        chk("t6_level_after_reset", 64'(level), 64'd0);
        rst = 1'b0;
        wr0 = wr_cnt;
        run(6);
        chk("t6_no_further_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("t6_level_still0", 64'(level), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
